// File: rtl/block_average_2_pkg.sv
// Shared constants, state encoding and rounding helper for the 2x2 block-average downscaler.
package block_average_2_pkg;

  localparam int IMG_WIDTH_IN   = 320;
  localparam int IMG_HEIGHT_IN  = 240;
  localparam int SHIFT_FACTOR   = 1;
  localparam int IMG_WIDTH_OUT  = IMG_WIDTH_IN >> SHIFT_FACTOR;
  localparam int IMG_HEIGHT_OUT = IMG_HEIGHT_IN >> SHIFT_FACTOR;

  localparam int R_ADDR_W = 17;
  localparam int W_ADDR_W = 15;
  localparam int PIX_W    = 8;
  localparam int ACC_W    = 10;
  localparam int CNT_W    = 8;
  localparam int K_W      = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  // Round-half-up mean of four pixels; 4*255+2 still fits in ACC_W bits.
  function automatic logic [PIX_W-1:0] round_avg4(input logic [ACC_W-1:0] sum);
    logic [ACC_W-1:0] t;
    t = sum + ACC_W'(2);
    return t[ACC_W-1:2];
  endfunction

endpackage

// File: rtl/block_average_2_if.sv
// Frame-control, source-read and destination-write signals of the downscaler.
interface block_average_2_if;
  import block_average_2_pkg::*;

  logic                start;
  logic [R_ADDR_W-1:0] r_addr;
  logic [PIX_W-1:0]    r_data;
  logic [W_ADDR_W-1:0] w_addr;
  logic [PIX_W-1:0]    w_data;
  logic                w_en;
  logic                busy;
  logic                done;

  modport slave  (input  start, r_data,
                  output r_addr, w_addr, w_data, w_en, busy, done);
  modport master (output start, r_data,
                  input  r_addr, w_addr, w_data, w_en, busy, done);
endinterface

// File: rtl/block_addr_gen.sv
// Maps destination pixel (ox, oy) and block tap k (TL, TR, BL, BR) to a row-major source address.
module block_addr_gen
  import block_average_2_pkg::*;
#(
  parameter int IMG_WIDTH_IN = block_average_2_pkg::IMG_WIDTH_IN
) (
  input  logic [CNT_W-1:0]    ox,
  input  logic [CNT_W-1:0]    oy,
  input  logic [K_W-1:0]      k,
  output logic [R_ADDR_W-1:0] addr
);

  logic [R_ADDR_W-1:0] row_s;
  logic [R_ADDR_W-1:0] col_s;

  // Source row is 2*oy+k[1], source column is 2*ox+k[0].
  always_comb begin
    row_s = R_ADDR_W'({oy, k[1]});
    col_s = R_ADDR_W'({ox, k[0]});
    addr  = row_s * R_ADDR_W'(IMG_WIDTH_IN) + col_s;
  end

endmodule

// File: rtl/block_average_2.sv
// 2x2 block-average downscaler: fetches four source pixels per destination pixel,
// then writes their rounded mean; six cycles per destination pixel.
module block_average_2
  import block_average_2_pkg::*;
#(
  parameter int IMG_WIDTH_IN  = block_average_2_pkg::IMG_WIDTH_IN,
  parameter int IMG_HEIGHT_IN = block_average_2_pkg::IMG_HEIGHT_IN,
  parameter int SHIFT_FACTOR  = block_average_2_pkg::SHIFT_FACTOR
) (
  input  logic               clk,
  input  logic               rst,
  block_average_2_if.slave   bus
);

  localparam int OUT_W = IMG_WIDTH_IN >> SHIFT_FACTOR;
  localparam int OUT_H = IMG_HEIGHT_IN >> SHIFT_FACTOR;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    ox_q, ox_d, oy_q, oy_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [R_ADDR_W-1:0] r_addr_q, r_addr_d;
  logic [W_ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [PIX_W-1:0]    w_data_q, w_data_d;
  logic                w_en_q, w_en_d, busy_q, busy_d, done_q, done_d;

  logic [CNT_W-1:0]    ox_nx_s, oy_nx_s, gen_ox_s, gen_oy_s;
  logic [K_W-1:0]      gen_k_s;
  logic [R_ADDR_W-1:0] gen_addr_s;
  logic [ACC_W-1:0]    sum_s;
  logic                last_px_s;

  // R_ADDR is registered, so the generator is fed the coordinates of the next cycle's fetch.
  always_comb begin
    if (ox_q == CNT_W'(OUT_W - 1)) begin
      ox_nx_s = '0;
      oy_nx_s = oy_q + CNT_W'(1);
    end else begin
      ox_nx_s = ox_q + CNT_W'(1);
      oy_nx_s = oy_q;
    end
    case (state_q)
      ST_IDLE:  begin gen_ox_s = '0;      gen_oy_s = '0;      gen_k_s = '0;            end
      ST_FETCH: begin gen_ox_s = ox_q;    gen_oy_s = oy_q;    gen_k_s = k_q + K_W'(1); end
      ST_WRITE: begin gen_ox_s = ox_nx_s; gen_oy_s = oy_nx_s; gen_k_s = '0;            end
      default:  begin gen_ox_s = ox_q;    gen_oy_s = oy_q;    gen_k_s = k_q;           end
    endcase
  end

  block_addr_gen #(.IMG_WIDTH_IN(IMG_WIDTH_IN)) u_addr_gen (
    .ox   (gen_ox_s),
    .oy   (gen_oy_s),
    .k    (gen_k_s),
    .addr (gen_addr_s)
  );

  // Next-state, counter, accumulator and output computation.
  always_comb begin
    state_d   = state_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    k_d       = k_q;
    acc_d     = acc_q;
    r_addr_d  = r_addr_q;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    w_en_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sum_s     = acc_q + ACC_W'(bus.r_data);
    last_px_s = (ox_q == CNT_W'(OUT_W - 1)) && (oy_q == CNT_W'(OUT_H - 1));
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_FETCH;
          ox_d     = '0;
          oy_d     = '0;
          k_d      = '0;
          acc_d    = '0;
          busy_d   = 1'b1;
          r_addr_d = gen_addr_s;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // Data for tap k arrives during tap k+1, so tap 0's cycle has nothing to add.
        if (k_q != K_W'(0)) begin
          acc_d = sum_s;
        end else begin
          acc_d = acc_q;
        end
        if (k_q == K_W'(3)) begin
          state_d = ST_DRAIN;
          k_d     = '0;
        end else begin
          k_d      = k_q + K_W'(1);
          r_addr_d = gen_addr_s;
        end
      end
      ST_DRAIN: begin
        acc_d    = sum_s;
        state_d  = ST_WRITE;
        w_en_d   = 1'b1;
        w_addr_d = W_ADDR_W'(oy_q) * W_ADDR_W'(OUT_W) + W_ADDR_W'(ox_q);
        w_data_d = round_avg4(sum_s);
      end
      ST_WRITE: begin
        acc_d = '0;
        if (last_px_s) begin
          state_d = ST_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d  = ST_FETCH;
          ox_d     = ox_nx_s;
          oy_d     = oy_nx_s;
          k_d      = '0;
          r_addr_d = gen_addr_s;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ox_q     <= '0;
      oy_q     <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      r_addr_q <= '0;
      w_addr_q <= '0;
      w_data_q <= '0;
      w_en_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      r_addr_q <= r_addr_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      w_en_q   <= w_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.r_addr = r_addr_q;
  assign bus.w_addr = w_addr_q;
  assign bus.w_data = w_data_q;
  assign bus.w_en   = w_en_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_block_average_2.sv
// Bench for block_average_2 on a reduced 32x16 image: cycle-by-cycle checks against a
// pixel-level model of fetch order, write timing and rounded averages.
module tb_block_average_2;
  import block_average_2_pkg::*;

  localparam int W     = 32;
  localparam int H     = 16;
  localparam int OW    = W / 2;
  localparam int OH    = H / 2;
  localparam int NPIX  = OW * OH;
  localparam int FRAME = NPIX * 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  block_average_2_if bus();

  block_average_2 #(.IMG_WIDTH_IN(W), .IMG_HEIGHT_IN(H), .SHIFT_FACTOR(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [W*H];
  int n_asrt = 0;
  int n_fail = 0;

  always @(posedge clk) bus.r_data <= mem[int'(bus.r_addr) % (W*H)];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_raddr(input int p, input int k);
    int ox, oy;
    ox = p % OW;
    oy = p / OW;
    return (2 * oy + k / 2) * W + 2 * ox + k % 2;
  endfunction

  function automatic int exp_wdata(input int p);
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) s += int'(mem[exp_raddr(p, k)]);
    return (s + 2) / 4;
  endfunction

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < W*H; i++) mem[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < W*H; i++) mem[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_r_addr"}, 32'(bus.r_addr), 32'd0);
    check({tag, "_w_addr"}, 32'(bus.w_addr), 32'd0);
    check({tag, "_w_data"}, 32'(bus.w_data), 32'd0);
    check({tag, "_w_en"},   32'(bus.w_en),   32'd0);
    check({tag, "_busy"},   32'(bus.busy),   32'd0);
    check({tag, "_done"},   32'(bus.done),   32'd0);
  endtask

  // Runs one frame, checking every cycle; abort_c asserts reset at that cycle, repulse_c re-pulses START.
  task automatic run_frame(input int abort_c, input int repulse_c, input bit chk_blk0);
    int writes, dones, p, ph;
    writes = 0;
    dones  = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c <= FRAME + 1; c++) begin
      if (c == abort_c) begin
        rst = 1'b1;
        #1;
        check_outputs_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      p  = c / 6;
      ph = c % 6;
      if (c < FRAME) begin
        check("busy", 32'(bus.busy), 32'd1);
        check("done_early", 32'(bus.done), 32'd0);
        check("w_en", 32'(bus.w_en), (ph == 5) ? 32'd1 : 32'd0);
        if (ph < 4) check("r_addr", 32'(bus.r_addr), 32'(exp_raddr(p, ph)));
        else        check("r_addr_hold", 32'(bus.r_addr), 32'(exp_raddr(p, 3)));
        if (ph == 5) begin
          check("w_addr", 32'(bus.w_addr), 32'(p));
          check("w_data", 32'(bus.w_data), 32'(exp_wdata(p)));
        end
        if (chk_blk0 && c == 5) check("blk0_avg", 32'(bus.w_data), 32'd25);
      end else if (c == FRAME) begin
        check("done", 32'(bus.done), 32'd1);
        check("busy_fin", 32'(bus.busy), 32'd0);
        check("w_en_fin", 32'(bus.w_en), 32'd0);
      end else begin
        check("done_pulse", 32'(bus.done), 32'd0);
        check("r_addr_idle", 32'(bus.r_addr), 32'(W * H - 1));
      end
      if (bus.w_en) writes++;
      if (bus.done) dones++;
      bus.start = (c == repulse_c);
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("write_count", 32'(writes), 32'(NPIX));
    check("done_count", 32'(dones), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    fill_const(8'h00);
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("idle");

    fill_const(8'h80);
    run_frame(-1, -1, 1'b0);

    fill_const(8'hFF);
    run_frame(-1, -1, 1'b0);

    fill_rand();
    mem[0]     = 8'd10;
    mem[1]     = 8'd20;
    mem[W]     = 8'd30;
    mem[W + 1] = 8'd41;
    run_frame(-1, 100, 1'b1);

    fill_rand();
    run_frame(50 * 6 + 2, -1, 1'b0);

    fill_rand();
    run_frame(-1, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/block_average_2.md
BLOCK_AVERAGE_2 -- requirements
Module: block_average_2

Interface
REQ-001 SHALL have parameter IMG_WIDTH_IN, default 320, source image width in pixels.
REQ-002 SHALL have parameter IMG_HEIGHT_IN, default 240, source image height in pixels.
REQ-003 SHALL have parameter SHIFT_FACTOR, default 1, log2 of the decimation factor; only value 1 is supported.
REQ-004 SHALL have a single clock and an asynchronous, active-high reset: CLK  in  1  rising-edge clock for all state.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 START  in  1  single-cycle request to process one frame; sampled only in IDLE.
REQ-007 R_ADDR  out  17  source-memory read address, row-major, y*IMG_WIDTH_IN+x, registered.
REQ-008 R_DATA  in  8  source pixel; valid exactly one cycle after the R_ADDR it answers.
REQ-009 W_ADDR  out  15  destination write address, oy*(IMG_WIDTH_IN/2)+ox, registered.
REQ-010 W_DATA  out  8  averaged destination pixel, registered.
REQ-011 W_EN  out  1  one-cycle write strobe qualifying W_ADDR/W_DATA.
REQ-012 BUSY  out  1  high from the cycle after accepted START until DONE.
REQ-013 DONE  out  1  one-cycle pulse marking frame completion.

Function
REQ-014 SHALL downscale 320x240 to 160x120 by averaging each 2x2 source block into one destination pixel.
REQ-015 SHALL traverse destination pixels row-major: ox 0..159 inner, oy 0..119 outer; ox wraps to 0 and oy increments after ox=159.
REQ-016 SHALL use states IDLE, FETCH, DRAIN, WRITE, FIN.
REQ-017 IDLE -> FETCH on START=1; ox, oy, k, and the accumulator are cleared on entry.
REQ-018 FETCH SHALL last 4 cycles (k=0..3), driving R_ADDR=(2*oy+k[1])*IMG_WIDTH_IN+(2*ox+k[0]), i.e. order TL, TR, BL, BR.
REQ-019 Accumulator SHALL be 10 bits and add R_DATA in the cycle after each FETCH address (FETCH k=1..3 and DRAIN).
REQ-020 FETCH k=3 -> DRAIN; DRAIN -> WRITE.
REQ-021 In WRITE: W_EN=1, W_ADDR=oy*160+ox, W_DATA=(sum+2)>>2 (round-half-up, max 255, no overflow); accumulator cleared.
REQ-022 WRITE -> FETCH for the next pixel, or -> FIN if ox=159 and oy=119.
REQ-023 FIN SHALL assert DONE=1 and BUSY=0 for one cycle, then return to IDLE.
REQ-024 Per-pixel cost SHALL be exactly 6 cycles; the frame occupies 115200 cycles from the first FETCH to the last WRITE inclusive.
REQ-025 START while not in IDLE SHALL be ignored, with no effect on counters or outputs.
REQ-026 W_EN SHALL be 0 in every state except WRITE; R_ADDR holds its last value outside FETCH.

Reset
REQ-027 RESET=1 SHALL force IDLE asynchronously, at any point including mid-frame.
REQ-028 RESET=1 SHALL clear to 0: R_ADDR, W_ADDR, W_DATA, W_EN, BUSY, DONE, ox, oy, k, and the accumulator.
REQ-029 The next START after reset SHALL restart the frame at W_ADDR 0; no partial state is retained.

Structure
REQ-030 A shared package SHALL hold IMG_WIDTH_IN, IMG_HEIGHT_IN, SHIFT_FACTOR, the derived output dimensions, the address widths (17/15), and the state encoding.
REQ-031 A combinational sub-module block_addr_gen SHALL map (ox, oy, k) to the source address; the FSM, counters, and accumulator live in block_average_2.

Verification
REQ-032 Source all 0x80, START pulse -> 19200 W_EN strobes, W_ADDR 0..19199 in order, all W_DATA=0x80, exactly one DONE pulse.
REQ-033 Block 0 = 10, 20, 30, 41 -> R_ADDR sequence 0, 1, 320, 321; W_ADDR 0 written with W_DATA 25 ((101+2)>>2).
REQ-034 Source all 0xFF -> every W_DATA=0xFF; sum reaches 1020 with no wrap.
REQ-035 Last block -> R_ADDR 76478, 76479, 76798, 76799; W_EN with W_ADDR 19199; DONE in the following cycle; BUSY low with DONE.
REQ-036 START re-pulsed while BUSY -> ignored, write count stays 19200; RESET at destination pixel 50 -> all outputs 0 immediately; subsequent START restarts at R_ADDR 0 / W_ADDR 0.
